// File: rtl/pmem_pkg.sv
// pmem_pkg: shared types and default sizing for the paged program memory.
//   pmem_state_t : pager FSM state, exported on STATE for debug.
//   PG_W/ADDR_W  : derived page-select and flat store address widths.
package pmem_pkg;

  localparam int PC_LEN    = 7;
  localparam int INSTR_LEN = 8;
  localparam int NUM_PAGES = 4;
  localparam int RST_HOLD  = 4;

  localparam int PG_W   = $clog2(NUM_PAGES);
  localparam int ADDR_W = PC_LEN + PG_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALTED = 3'd4
  } pmem_state_t;

endpackage

// File: rtl/pmem_store.sv
// pmem_store: instruction array, one synchronous write port and one
// combinational read port. No reset, so contents survive RSTN.
//   CLK          : write clock
//   we/waddr/wdata : write port
//   raddr/rdata  : asynchronous read port
module pmem_store #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pmem_pager.sv
// pmem_pager: program memory stage in front of the core. A byte-stream load
// port fills a paged store; once loading ends the core is held in reset for
// RST_HOLD cycles and then released. In RUN the store is read at {page, PC}.
// Optional halt-loop detection is built when PMEM_HALT_DETECT_EN is defined.
//   CLK, RSTN                : clock, async active-low reset
//   LD_START/VALID/DATA/LAST : load stream in, LD_READY out
//   PG_WE, PG_SEL            : page-select write
//   PC -> INSTR              : instruction fetch
//   CORE_RSTN, STATE, HALT   : core reset, debug state, halt flag
module pmem_pager #(
  parameter int PC_LEN    = pmem_pkg::PC_LEN,
  parameter int INSTR_LEN = pmem_pkg::INSTR_LEN,
  parameter int NUM_PAGES = pmem_pkg::NUM_PAGES,
  parameter int RST_HOLD  = pmem_pkg::RST_HOLD
) (
  input  logic                         CLK,
  input  logic                         RSTN,
  input  logic                         LD_START,
  input  logic                         LD_VALID,
  input  logic [INSTR_LEN-1:0]         LD_DATA,
  input  logic                         LD_LAST,
  output logic                         LD_READY,
  input  logic                         PG_WE,
  input  logic [$clog2(NUM_PAGES)-1:0] PG_SEL,
  input  logic [PC_LEN-1:0]            PC,
  output logic [INSTR_LEN-1:0]         INSTR,
  output logic                         CORE_RSTN,
  output logic [2:0]                   STATE,
  output logic                         HALT
);
  import pmem_pkg::*;

  localparam int PAGE_W = $clog2(NUM_PAGES);
  localparam int AW     = PC_LEN + PAGE_W;
  localparam int HC_W   = $clog2(RST_HOLD + 1);

  pmem_state_t           state, nxt;
  logic [AW-1:0]         addr;
  logic [PAGE_W-1:0]     page;
  logic [HC_W-1:0]       hold_cnt;
  logic                  we, hold_done, run_like, halt_hit;
  logic [INSTR_LEN-1:0]  rdata;

  assign run_like  = (state == ST_RUN) || (state == ST_HALTED);
  assign hold_done = (hold_cnt == HC_W'(RST_HOLD - 1));

  always_comb begin
    nxt = state;
    we  = 1'b0;
    if (LD_START) begin
      // restart from any state wins over everything else this cycle
      nxt = ST_LOAD;
    end else begin
      case (state)
        ST_IDLE:   nxt = ST_IDLE;
        ST_LOAD: begin
          if (LD_VALID) begin
            we = 1'b1;
            // last address ends the load even without LD_LAST; no wrap
            if (LD_LAST || addr == {AW{1'b1}}) nxt = ST_HOLD;
          end
        end
        ST_HOLD:   if (hold_done) nxt = ST_RUN;
        ST_RUN:    if (halt_hit) nxt = ST_HALTED;
        ST_HALTED: nxt = ST_HALTED;
        default:   nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= ST_IDLE;
      addr     <= '0;
      page     <= '0;
      hold_cnt <= '0;
    end else begin
      state <= nxt;
      if (LD_START) begin
        addr <= '0;
        page <= '0;
      end else begin
        if (we) addr <= addr + 1'b1;
        if (PG_WE && run_like) page <= PG_SEL;
      end
      // counts HOLD cycles from entry; zero everywhere else
      if (state == ST_HOLD && !LD_START && !hold_done) hold_cnt <= hold_cnt + 1'b1;
      else                                             hold_cnt <= '0;
    end
  end

`ifdef PMEM_HALT_DETECT_EN
  logic [PC_LEN-1:0] last_pc;
  logic              pc_vld;

  assign halt_hit = (state == ST_RUN) && pc_vld && (PC == last_pc);

  // pc_vld drops outside RUN (so RUN entry starts clean) and on a page switch
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      last_pc <= '0;
      pc_vld  <= 1'b0;
    end else if (state == ST_RUN && !PG_WE) begin
      last_pc <= PC;
      pc_vld  <= 1'b1;
    end else begin
      pc_vld  <= 1'b0;
    end
  end

  // flag rises in the repeating cycle itself, then holds via HALTED
  assign HALT = halt_hit || (state == ST_HALTED);
`else
  assign halt_hit = 1'b0;
  assign HALT     = 1'b0;
`endif

  pmem_store #(.AW(AW), .DW(INSTR_LEN)) u_store (
    .CLK   (CLK),
    .we    (we),
    .waddr (addr),
    .wdata (LD_DATA),
    .raddr ({page, PC}),
    .rdata (rdata)
  );

  assign LD_READY  = (state == ST_LOAD);
  assign CORE_RSTN = run_like;
  assign INSTR     = run_like ? rdata : '0;
  assign STATE     = state;

endmodule

// File: tb/tb_pmem_pager.sv
module tb_pmem_pager;

  localparam int PCL = 7, IL = 8, NP = 4, RH = 4;
  localparam int WORDS = NP << PCL;
`ifdef PMEM_HALT_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          LD_START, LD_VALID, LD_LAST, LD_READY, PG_WE;
  logic [IL-1:0] LD_DATA, INSTR;
  logic [1:0]    PG_SEL;
  logic [PCL-1:0] PC;
  logic          CORE_RSTN, HALT;
  logic [2:0]    STATE;

  pmem_pager #(.PC_LEN(PCL), .INSTR_LEN(IL), .NUM_PAGES(NP), .RST_HOLD(RH)) dut (
    .CLK(CLK), .RSTN(RSTN), .LD_START(LD_START), .LD_VALID(LD_VALID),
    .LD_DATA(LD_DATA), .LD_LAST(LD_LAST), .LD_READY(LD_READY), .PG_WE(PG_WE),
    .PG_SEL(PG_SEL), .PC(PC), .INSTR(INSTR), .CORE_RSTN(CORE_RSTN),
    .STATE(STATE), .HALT(HALT)
  );

  always #5 CLK = ~CLK;

  // reference: flat image of what has been loaded, plus the active page
  logic [IL-1:0] mem_m [WORDS];
  int            page_m;
  logic [IL-1:0] wq [$];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK); #1;
  endtask

  function automatic logic [IL-1:0] ref_instr(input int pg, input int pc);
    return mem_m[pg * (1 << PCL) + pc];
  endfunction

  // pulse LD_START, stream wq, then walk through the reset hold into RUN
  task automatic load_q(input bit use_last);
    LD_START = 1; cyc(); LD_START = 0; #1;
    chk("ld_state", STATE, 1);
    for (int i = 0; i < wq.size(); i++) begin
      LD_VALID = 1; LD_DATA = wq[i]; LD_LAST = use_last && (i == wq.size() - 1); #1;
      chk("ld_ready", LD_READY, 1);
      chk("ld_instr0", INSTR, 0);
      mem_m[i] = wq[i];
      cyc();
    end
    LD_VALID = 0; LD_LAST = 0;
    for (int k = 0; k < RH; k++) begin
      if (k == 0 && !use_last) begin LD_VALID = 1; LD_DATA = ~mem_m[0]; end
      #1;
      chk("hold_state", STATE, 2);
      chk("hold_rstn", CORE_RSTN, 0);
      chk("hold_instr0", INSTR, 0);
      chk("hold_ready", LD_READY, 0);
      cyc();
      LD_VALID = 0;
    end
    #1;
    chk("run_state", STATE, 3);
    chk("run_rstn", CORE_RSTN, 1);
    page_m = 0;
  endtask

  initial begin
    int prev, pc_r;
    RSTN = 0; LD_START = 0; LD_VALID = 0; LD_LAST = 0; LD_DATA = 0;
    PG_WE = 0; PG_SEL = 0; PC = 0;
    #1;
    chk("rst_state", STATE, 0);
    chk("rst_core", CORE_RSTN, 0);
    chk("rst_ready", LD_READY, 0);
    chk("rst_instr", INSTR, 0);
    chk("rst_halt", HALT, 0);
    cyc(); cyc(); RSTN = 1; cyc();
    chk("idle_state", STATE, 0);

    // three words, LD_LAST on the third, then PC walk and halt loop
    wq = '{8'hA1, 8'hB2, 8'hC3};
    load_q(1);
    PC = 0; #1; chk("t1_pc0", INSTR, 8'hA1); cyc();
    PC = 1; #1; chk("t1_pc1", INSTR, 8'hB2); cyc();
    PC = 2; #1; chk("t1_pc2", INSTR, 8'hC3); chk("t1_nohalt", HALT, 0); cyc();
    PC = 2; #1; chk("halt_hit", HALT, HD); chk("halt_instr", INSTR, 8'hC3); cyc();
    #1;
    chk("halt_state", STATE, HD ? 4 : 3);
    chk("halt_sticky", HALT, HD);
    chk("halt_rstn", CORE_RSTN, 1);
    LD_START = 1; cyc(); LD_START = 0; #1;
    chk("restart_state", STATE, 1);
    chk("restart_rstn", CORE_RSTN, 0);
    chk("restart_halt", HALT, 0);

    // 130 index-valued words, then switch to page 1
    wq.delete();
    for (int i = 0; i < 130; i++) wq.push_back(IL'(i));
    load_q(1);
    PG_WE = 1; PG_SEL = 1; PC = 0; #1;
    chk("pg_old", INSTR, ref_instr(page_m, 0));
    cyc(); PG_WE = 0; page_m = 1;
    PC = 0; #1; chk("pg1_pc0", INSTR, 8'h80); cyc();
    PC = 1; #1; chk("pg1_pc1", INSTR, 8'h81); cyc();

    // full 512 random words with no LD_LAST, then random page/PC reads
    wq.delete();
    for (int i = 0; i < WORDS; i++) wq.push_back(IL'($urandom));
    load_q(0);
    PC = 0; #1; chk("full_nowrap", INSTR, ref_instr(0, 0)); cyc();
    prev = 0;
    for (int j = 0; j < 16; j++) begin
      // PC steps in the page-write cycle so the halt detector never fires
      PG_WE = 1; PG_SEL = 2'($urandom); PC = PCL'(prev + 1); #1;
      chk("rnd_pre", INSTR, ref_instr(page_m, (prev + 1) % (1 << PCL)));
      cyc(); PG_WE = 0; page_m = PG_SEL;
      pc_r = int'($urandom_range((1 << PCL) - 1, 0));
      PC = PCL'(pc_r); #1;
      chk("rnd_rd", INSTR, ref_instr(page_m, pc_r));
      prev = pc_r;
      cyc();
    end

    // reset in the middle of a load keeps the words already written
    LD_START = 1; cyc(); LD_START = 0;
    for (int i = 0; i < 5; i++) begin
      LD_VALID = 1; LD_DATA = IL'($urandom); mem_m[i] = LD_DATA; cyc();
    end
    LD_VALID = 0; RSTN = 0; #1;
    chk("mid_state", STATE, 0);
    chk("mid_rstn", CORE_RSTN, 0);
    chk("mid_ready", LD_READY, 0);
    cyc(); RSTN = 1; cyc();
    wq = '{mem_m[0]};
    load_q(1);
    for (int p = 1; p <= 5; p++) begin
      PC = PCL'(p); #1; chk("mid_keep", INSTR, ref_instr(0, p)); cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
